// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants, state encoding and entry type for the fetch stage
package if_fetch_pkg;

  localparam logic [31:0] INST_NOP           = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small instruction buffer of {addr, inst} entries; flush wins over push
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: empty_o masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RV32I fetch stage: owns the PC, one outstanding bus read, buffers words for decode
module if_fetch import if_fetch_pkg::*; #(
  parameter logic [31:0]  RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter int unsigned  FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          drop_q, drop_d;

  logic          push, pop, room;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] count, count_next;
  logic [31:0]   jump_target;
  fetch_entry_t  head, wentry;

  assign jump_target = word_align(jump_addr_i);
  assign pop         = !fifo_empty && inst_ready_i;
  assign push        = (state_q == FETCH_WAIT) && ibus_rvalid_i && !drop_q &&
                       !jump_flag_i && !fifo_full;
  assign wentry      = '{addr: req_addr_q, inst: ibus_rdata_i};

  // Occupancy after this edge decides whether the next request may go out.
  always_comb begin
    count_next = count;
    if (jump_flag_i)          count_next = '0;
    else if (push && !pop)    count_next = count + 1'b1;
    else if (pop && !push)    count_next = count - 1'b1;
  end
  assign room = (32'(count_next) < FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    ibus_req_o = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (jump_flag_i) pc_d = jump_target;
        else if (room)   state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        ibus_req_o = 1'b1;
        if (ibus_gnt_i) begin
          req_addr_d = pc_q;
          state_d    = FETCH_WAIT;
          if (jump_flag_i) begin
            drop_d = 1'b1;
            pc_d   = jump_target;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end else if (jump_flag_i) begin
          pc_d = jump_target;
        end
      end
      FETCH_WAIT: begin
        if (ibus_rvalid_i) begin
          drop_d  = 1'b0;
          if (jump_flag_i) pc_d = jump_target;
          state_d = room ? FETCH_REQ : FETCH_IDLE;
        end else if (jump_flag_i) begin
          drop_d = 1'b1;
          pc_d   = jump_target;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_ADDR;
      req_addr_q <= RESET_ADDR;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
    end
  end

  assign ibus_addr_o = pc_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (jump_flag_i),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? INST_NOP : head.inst;
  assign inst_addr_o  = fifo_empty ? 32'h0 : head.addr;

endmodule
